// File: rtl/iso7816_pkg.sv
// Shared definitions for the ISO 7816 ATR parser: the parser state encoding,
// the protocol numbers carried in TDi, TA1 defaults and the size limit.
// The field-dispatch helper decides which ATR field the next byte belongs to.
package iso7816_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WAIT_T0 = 4'd1,
    ST_NEXT    = 4'd2,
    ST_TA      = 4'd3,
    ST_TB      = 4'd4,
    ST_TC      = 4'd5,
    ST_TD      = 4'd6,
    ST_HIST    = 4'd7,
    ST_TCK     = 4'd8,
    ST_DONE    = 4'd9,
    ST_ERR     = 4'd10
  } atr_state_t;

  localparam logic [3:0] T_0  = 4'd0;
  localparam logic [3:0] T_1  = 4'd1;
  localparam logic [3:0] T_15 = 4'd15;

  localparam logic [3:0] FI_CODE_DEFAULT = 4'b0001;
  localparam logic [3:0] DI_CODE_DEFAULT = 4'b0001;

  localparam int MAX_ATR_BYTES_DEFAULT = 32;

  // Resolves the transient NEXT decision: pending interface bytes first
  // (TA, TB, TC, TD in that order), then historical bytes, then TCK.
  function automatic atr_state_t next_field(input logic [3:0] y,
                                            input logic [3:0] hist_left,
                                            input logic       need_tck);
    atr_state_t st;
    if (y[0])                 st = ST_TA;
    else if (y[1])            st = ST_TB;
    else if (y[2])            st = ST_TC;
    else if (y[3])            st = ST_TD;
    else if (hist_left != '0) st = ST_HIST;
    else if (need_tck)        st = ST_TCK;
    else                      st = ST_DONE;
    return st;
  endfunction

endpackage

// File: rtl/iso7816_atr_tck_checker.sv
// Running XOR over every ATR byte from T0 up to and including TCK.
// A non-zero result once the TCK byte has been folded in flags a checksum
// error, which stays set until the session is cleared.
module iso7816_atr_tck_checker (
  input  logic       clk,
  input  logic       clr_i,
  input  logic       acc_i,
  input  logic       last_i,
  input  logic [7:0] data_i,
  output logic       tck_error_o
);

  logic [7:0] xor_q;
  logic [7:0] xor_d;
  logic       err_q;

  assign xor_d = xor_q ^ data_i;

  // Accumulate accepted bytes; judge the total on the TCK byte.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      xor_q <= 8'h00;
      err_q <= 1'b0;
    end else if (acc_i) begin
      xor_q <= xor_d;
      if (last_i && (xor_d != 8'h00)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tck_error_o = err_q;

endmodule

// File: rtl/iso7816_atr_parser.sv
// ISO 7816 ATR byte-level parser. Consumes convention-corrected bytes after
// TS and walks T0, TAi/TBi/TCi/TDi, historical bytes and TCK, publishing the
// TA1 codes, offered protocols and completion/error flags.
// Optional feature: define ISO7816_ATR_TCK_CHECK_EN to verify the TCK
// checksum; otherwise tckError is constant 0 and TCK is consumed unchecked.
module iso7816_atr_parser
  import iso7816_pkg::*;
#(
  parameter int MAX_ATR_BYTES = MAX_ATR_BYTES_DEFAULT,
  parameter int CNT_WIDTH     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 isActivated,
  input  logic                 tsReceived,
  input  logic                 byteValid,
  input  logic [7:0]           byteData,
  output logic                 t0Received,
  output logic                 atrCompleted,
  output logic                 atrError,
  output logic                 tckError,
  output logic [3:0]           fiCode,
  output logic [3:0]           diCode,
  output logic                 useT0,
  output logic                 useT1,
  output logic                 useT15,
  output logic [3:0]           histCount,
  output logic [CNT_WIDTH-1:0] atrByteCount
);

  atr_state_t           state_q;
  logic                 t0_received_q;
  logic                 atr_completed_q;
  logic                 atr_error_q;
  logic [3:0]           fi_code_q;
  logic [3:0]           di_code_q;
  logic                 use_t0_q;
  logic                 use_t1_q;
  logic                 use_t15_q;
  logic [3:0]           hist_count_q;
  logic [CNT_WIDTH-1:0] byte_cnt_q;

  // Walk bookkeeping: pending interface bytes, group index, remaining
  // historical bytes, whether a TCK will follow, whether any TDi was seen.
  logic [3:0]           y_q;
  logic [3:0]           idx_q;
  logic [3:0]           hist_left_q;
  logic                 need_tck_q;
  logic                 td_seen_q;

  // Values these registers take once the current byte has been consumed.
  logic [3:0]           y_d;
  logic [3:0]           hist_left_d;
  logic                 need_tck_d;
  logic                 td_seen_d;
  atr_state_t           state_d;

  logic                 session_clr;
  logic                 byte_in_field;
  logic                 byte_overflow;
  logic                 byte_accept;
  logic [3:0]           td_proto;

  assign session_clr = reset || !isActivated;
  assign td_proto    = byteData[3:0];

  // Only the field-consuming states take bytes; IDLE, DONE and ERR ignore them.
  always_comb begin
    byte_in_field = 1'b0;
    case (state_q)
      ST_WAIT_T0, ST_TA, ST_TB, ST_TC, ST_TD, ST_HIST, ST_TCK: byte_in_field = 1'b1;
      default: byte_in_field = 1'b0;
    endcase
  end

  // A byte arriving with the counter already at the limit would overflow it.
  assign byte_overflow = byteValid && byte_in_field &&
                         (byte_cnt_q == CNT_WIDTH'(MAX_ATR_BYTES));
  assign byte_accept   = byteValid && byte_in_field && !byte_overflow;

  // Update the walk bookkeeping for the current byte and pick the field that
  // the following byte belongs to, so NEXT never lasts a cycle of its own.
  always_comb begin
    y_d         = y_q;
    hist_left_d = hist_left_q;
    need_tck_d  = need_tck_q;
    td_seen_d   = td_seen_q;
    case (state_q)
      ST_WAIT_T0: begin
        y_d         = byteData[7:4];
        hist_left_d = byteData[3:0];
      end
      ST_TA: y_d[0] = 1'b0;
      ST_TB: y_d[1] = 1'b0;
      ST_TC: y_d[2] = 1'b0;
      ST_TD: begin
        y_d       = byteData[7:4];
        td_seen_d = 1'b1;
        if (td_proto != T_0) need_tck_d = 1'b1;
      end
      ST_HIST: hist_left_d = hist_left_q - 4'd1;
      default: ;
    endcase
    if (state_q == ST_TCK) state_d = ST_DONE;
    else                   state_d = next_field(y_d, hist_left_d, need_tck_d);
  end

  // Parser state machine with registered outputs; session clear wins over bytes.
  always_ff @(posedge clk) begin
    if (session_clr) begin
      state_q         <= ST_IDLE;
      t0_received_q   <= 1'b0;
      atr_completed_q <= 1'b0;
      atr_error_q     <= 1'b0;
      fi_code_q       <= FI_CODE_DEFAULT;
      di_code_q       <= DI_CODE_DEFAULT;
      use_t0_q        <= 1'b0;
      use_t1_q        <= 1'b0;
      use_t15_q       <= 1'b0;
      hist_count_q    <= 4'd0;
      byte_cnt_q      <= '0;
      y_q             <= 4'd0;
      idx_q           <= 4'd0;
      hist_left_q     <= 4'd0;
      need_tck_q      <= 1'b0;
      td_seen_q       <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (tsReceived) state_q <= ST_WAIT_T0;
    end else if (byte_overflow) begin
      state_q     <= ST_ERR;
      atr_error_q <= 1'b1;
    end else if (byte_accept) begin
      byte_cnt_q  <= byte_cnt_q + CNT_WIDTH'(1);
      y_q         <= y_d;
      hist_left_q <= hist_left_d;
      need_tck_q  <= need_tck_d;
      td_seen_q   <= td_seen_d;
      state_q     <= state_d;

      case (state_q)
        ST_WAIT_T0: begin
          t0_received_q <= 1'b1;
          hist_count_q  <= byteData[3:0];
          idx_q         <= 4'd1;
        end
        ST_TA: begin
          if (idx_q == 4'd1) begin
            fi_code_q <= byteData[7:4];
            di_code_q <= byteData[3:0];
          end
        end
        ST_TD: begin
          // Group index saturates so a long TD chain never wraps back to 1.
          if (idx_q != 4'd15) idx_q <= idx_q + 4'd1;
          if (td_proto == T_0)  use_t0_q  <= 1'b1;
          if (td_proto == T_1)  use_t1_q  <= 1'b1;
          if (td_proto == T_15) use_t15_q <= 1'b1;
        end
        default: ;
      endcase

      if (state_d == ST_DONE) begin
        atr_completed_q <= 1'b1;
        // No TDi at all means the card implicitly offers T=0.
        if (!td_seen_d) use_t0_q <= 1'b1;
      end
    end
  end

`ifdef ISO7816_ATR_TCK_CHECK_EN
  logic tck_last;
  logic tck_error_w;

  assign tck_last = byte_accept && (state_q == ST_TCK);

  iso7816_atr_tck_checker u_tck_checker (
    .clk         (clk),
    .clr_i       (session_clr),
    .acc_i       (byte_accept),
    .last_i      (tck_last),
    .data_i      (byteData),
    .tck_error_o (tck_error_w)
  );

  assign tckError = tck_error_w;
`else
  assign tckError = 1'b0;
`endif

  assign t0Received   = t0_received_q;
  assign atrCompleted = atr_completed_q;
  assign atrError     = atr_error_q;
  assign fiCode       = fi_code_q;
  assign diCode       = di_code_q;
  assign useT0        = use_t0_q;
  assign useT1        = use_t1_q;
  assign useT15       = use_t15_q;
  assign histCount    = hist_count_q;
  assign atrByteCount = byte_cnt_q;

endmodule

// File: tb/tb_iso7816_atr_parser.sv
// Bench for iso7816_atr_parser: a prefix-based ATR model recomputes the
// expected outputs from the list of bytes seen since TS on every cycle, and
// directed scenarios add hand-computed literal checks.
module tb_iso7816_atr_parser;

  localparam int MAX_BYTES = 32;
  localparam int CW        = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          isActivated = 1'b1;
  logic          tsReceived = 1'b0;
  logic          byteValid = 1'b0;
  logic [7:0]    byteData = 8'h00;
  logic          t0Received, atrCompleted, atrError, tckError;
  logic [3:0]    fiCode, diCode, histCount;
  logic          useT0, useT1, useT15;
  logic [CW-1:0] atrByteCount;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  iso7816_atr_parser #(.MAX_ATR_BYTES(MAX_BYTES), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .isActivated  (isActivated),
    .tsReceived   (tsReceived),
    .byteValid    (byteValid),
    .byteData     (byteData),
    .t0Received   (t0Received),
    .atrCompleted (atrCompleted),
    .atrError     (atrError),
    .tckError     (tckError),
    .fiCode       (fiCode),
    .diCode       (diCode),
    .useT0        (useT0),
    .useT1        (useT1),
    .useT15       (useT15),
    .histCount    (histCount),
    .atrByteCount (atrByteCount)
  );

  typedef struct {
    bit       t0r, done, err, tckerr, u0, u1, u15;
    bit [3:0] fi, di, k;
    int       cnt;
  } exp_t;

  // Bytes delivered since TS in the current session.
  logic [7:0] mq[$];
  bit         m_ts = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit take(inout int idx, inout exp_t e, output logic [7:0] b);
    b = 8'h00;
    if (idx >= mq.size()) return 1'b0;
    if (idx >= MAX_BYTES) begin
      e.err = 1'b1;
      return 1'b0;
    end
    b = mq[idx];
    idx++;
    e.cnt = idx;
    return 1'b1;
  endfunction

  // Parse the byte prefix as an ATR: T0, interface groups, K historical
  // bytes, optional TCK. Bytes beyond completion or the limit are ignored.
  function automatic exp_t parse();
    exp_t       e;
    logic [7:0] b;
    logic [7:0] x;
    logic [3:0] y, ynext;
    int         idx, grp;
    bit         td_any, tck_req, more;
    e.t0r = 0; e.done = 0; e.err = 0; e.tckerr = 0;
    e.u0 = 0; e.u1 = 0; e.u15 = 0;
    e.fi = 4'd1; e.di = 4'd1; e.k = 4'd0; e.cnt = 0;
    idx = 0; td_any = 0; tck_req = 0;
    if (!take(idx, e, b)) return e;
    e.t0r = 1'b1;
    e.k   = b[3:0];
    y     = b[7:4];
    grp   = 1;
    do begin
      more  = 1'b0;
      ynext = 4'd0;
      for (int f = 0; f < 4; f++) begin
        if (y[f]) begin
          if (!take(idx, e, b)) return e;
          if (f == 0 && grp == 1) begin
            e.fi = b[7:4];
            e.di = b[3:0];
          end
          if (f == 3) begin
            more   = 1'b1;
            td_any = 1'b1;
            ynext  = b[7:4];
            if (b[3:0] == 4'd0)  e.u0  = 1'b1;
            if (b[3:0] == 4'd1)  e.u1  = 1'b1;
            if (b[3:0] == 4'd15) e.u15 = 1'b1;
            if (b[3:0] != 4'd0)  tck_req = 1'b1;
          end
        end
      end
      y = ynext;
      grp++;
    end while (more);
    for (int h = 0; h < int'(e.k); h++) begin
      if (!take(idx, e, b)) return e;
    end
    if (tck_req) begin
      if (!take(idx, e, b)) return e;
`ifdef ISO7816_ATR_TCK_CHECK_EN
      x = 8'h00;
      for (int j = 0; j < idx; j++) x = x ^ mq[j];
      e.tckerr = (x != 8'h00);
`else
      x = 8'h00;
      e.tckerr = (x != 8'h00);
`endif
    end
    e.done = 1'b1;
    if (!td_any) e.u0 = 1'b1;
    return e;
  endfunction

  // Track the session from the inputs the DUT samples at each edge.
  always @(posedge clk) begin
    if (reset || !isActivated) begin
      mq.delete();
      m_ts = 1'b0;
    end else if (!m_ts) begin
      if (tsReceived) m_ts = 1'b1;
    end else if (byteValid) begin
      mq.push_back(byteData);
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      e = parse();
      chk("t0Received",   32'(t0Received),   32'(e.t0r));
      chk("atrCompleted", 32'(atrCompleted), 32'(e.done));
      chk("atrError",     32'(atrError),     32'(e.err));
      chk("tckError",     32'(tckError),     32'(e.tckerr));
      chk("fiCode",       32'(fiCode),       32'(e.fi));
      chk("diCode",       32'(diCode),       32'(e.di));
      chk("useT0",        32'(useT0),        32'(e.u0));
      chk("useT1",        32'(useT1),        32'(e.u1));
      chk("useT15",       32'(useT15),       32'(e.u15));
      chk("histCount",    32'(histCount),    32'(e.k));
      chk("atrByteCount", 32'(atrByteCount), 32'(e.cnt));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tsReceived = 1'b0;
    byteValid = 1'b0;
    isActivated = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_ts();
    tsReceived = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    byteValid = 1'b1;
    byteData  = b;
    @(negedge clk);
    byteValid = 1'b0;
    $display("byte 0x%02h -> done=%0d err=%0d cnt=%0d", b, atrCompleted, atrError, atrByteCount);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    do_reset();
    cmp_en = 1'b1;
    chk("rst_done", 32'(atrCompleted), 32'd0);
    chk("rst_fi",   32'(fiCode),       32'd1);
    chk("rst_di",   32'(diCode),       32'd1);
    chk("rst_cnt",  32'(atrByteCount), 32'd0);

    // Minimal ATR: T0=0x00
    start_ts();
    send(8'h00);
    chk("min_done", 32'(atrCompleted), 32'd1);
    chk("min_t0",   32'(useT0),        32'd1);
    chk("min_cnt",  32'(atrByteCount), 32'd1);
    chk("min_t0r",  32'(t0Received),   32'd1);

    // TA1 plus one historical byte
    do_reset();
    start_ts();
    send(8'h11); send(8'h95); send(8'h80);
    chk("ta1_fi",   32'(fiCode),       32'd9);
    chk("ta1_di",   32'(diCode),       32'd5);
    chk("ta1_k",    32'(histCount),    32'd1);
    chk("ta1_done", 32'(atrCompleted), 32'd1);
    chk("ta1_t0",   32'(useT0),        32'd1);

    // T=1 with a correct TCK
    do_reset();
    start_ts();
    send(8'h80); send(8'h01); send(8'h81);
    chk("t1_u1",   32'(useT1),        32'd1);
    chk("t1_u0",   32'(useT0),        32'd0);
    chk("t1_done", 32'(atrCompleted), 32'd1);
    chk("t1_tck",  32'(tckError),     32'd0);

    // T=1 with a wrong TCK
    do_reset();
    start_ts();
    send(8'h80); send(8'h01); send(8'h82);
    chk("badtck_done", 32'(atrCompleted), 32'd1);
`ifdef ISO7816_ATR_TCK_CHECK_EN
    chk("badtck_err", 32'(tckError), 32'd1);
`else
    chk("badtck_err", 32'(tckError), 32'd0);
`endif

    // TA1/TD1 -> TD2 (T=15) -> TA3 ignored -> TCK
    do_reset();
    start_ts();
    send(8'h90); send(8'h18); send(8'h81); send(8'h1F); send(8'h55); send(8'h43);
    chk("chain_fi",  32'(fiCode),       32'd1);
    chk("chain_di",  32'(diCode),       32'd8);
    chk("chain_u15", 32'(useT15),       32'd1);
    chk("chain_cnt", 32'(atrByteCount), 32'd6);
    chk("chain_tck", 32'(tckError),     32'd0);

    // TA1, TB1, TC1 and one historical byte
    do_reset();
    start_ts();
    send(8'h71); send(8'h13); send(8'h00); send(8'hFF); send(8'h41);
    chk("abc_di",   32'(diCode),       32'd3);
    chk("abc_done", 32'(atrCompleted), 32'd1);
    chk("abc_cnt",  32'(atrByteCount), 32'd5);

    // Endless TD chain overflows on the 33rd byte; later bytes ignored
    do_reset();
    start_ts();
    for (int n = 0; n < 41; n++) send(8'h80);
    chk("ovf_err",  32'(atrError),     32'd1);
    chk("ovf_done", 32'(atrCompleted), 32'd0);
    chk("ovf_cnt",  32'(atrByteCount), 32'd32);

    // Deactivation before TA1, then reactivation
    do_reset();
    start_ts();
    send(8'h11);
    isActivated = 1'b0;
    @(negedge clk);
    chk("deact_t0r", 32'(t0Received),   32'd0);
    chk("deact_k",   32'(histCount),    32'd0);
    chk("deact_cnt", 32'(atrByteCount), 32'd0);
    isActivated = 1'b1;
    @(negedge clk);
    send(8'h00);
    chk("react_done", 32'(atrCompleted), 32'd1);

    // byteValid coincident with reset is ignored
    do_reset();
    start_ts();
    reset = 1'b1;
    byteValid = 1'b1;
    byteData = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    byteValid = 1'b0;
    chk("rstbyte_done", 32'(atrCompleted), 32'd0);
    chk("rstbyte_cnt",  32'(atrByteCount), 32'd0);
    @(negedge clk);
    send(8'h00);
    chk("rstbyte_redo", 32'(atrCompleted), 32'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iso7816_atr_parser.md
Name: iso7816_atr_parser

Overview:
- Byte-level ATR decoder downstream of the T=0 analyzer's receive core and TS analyzer.
- Consumes convention-corrected bytes after TS and walks T0/TAi/TBi/TCi/TDi/historical/TCK.
- Produces atrCompleted, t0Received, fiCode/diCode and protocol flags (useT0/useT1/useT15) for the T=0 monitoring state machine.

Parameters:
- MAX_ATR_BYTES, 32, maximum bytes after TS before atrError is raised.
- CNT_WIDTH, 6, width of the byte counter; must satisfy 2^CNT_WIDTH > MAX_ATR_BYTES.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- isActivated  input  1  card session active; low means deactivated.
- tsReceived  input  1  level; TS accepted upstream, parsing starts from the next byte.
- byteValid  input  1  one-cycle strobe; byteData valid (endOfRx equivalent).
- byteData  input  8  received byte, already convention-corrected.
- t0Received  output  1  T0 byte consumed.
- atrCompleted  output  1  ATR fully parsed; sticky.
- atrError  output  1  overlength ATR; sticky.
- tckError  output  1  TCK checksum mismatch; sticky.
- fiCode  output  4  Fi code from TA1.
- diCode  output  4  Di code from TA1.
- useT0  output  1  T=0 offered.
- useT1  output  1  T=1 offered.
- useT15  output  1  T=15 global bytes present.
- histCount  output  4  K, taken from T0 low nibble.
- atrByteCount  output  CNT_WIDTH  bytes consumed after TS.

Behaviour:
- Reset values: all flags 0, fiCode=4'b0001, diCode=4'b0001, histCount=0, atrByteCount=0, state IDLE.
- Reset is synchronous; asserting it mid-ATR aborts parsing and restores reset values on the next edge.
- isActivated low: same effect as reset. It has priority over a simultaneous byteValid.
- All outputs are registered. A byte sampled with byteValid at edge n is reflected in the outputs after edge n. byteValid is ignored in IDLE, DONE and ERR.
- Each accepted byte increments atrByteCount.
- If a byte would make atrByteCount exceed MAX_ATR_BYTES: go to ERR, set atrError=1, leave atrCompleted=0.
- Internal state:
  - Y[3:0]: pending TA/TB/TC/TD presence bits.
  - i: interface group index, 4 bits, saturating at 15.
  - histLeft: remaining historical bytes.
  - needTck: TCK expected.
  - tdSeen: at least one TDi received.
- IDLE: when tsReceived=1, go to WAIT_T0.
- WAIT_T0 on byte: Y=hi nibble, histCount=histLeft=lo nibble, t0Received=1, i=1, then NEXT.
- NEXT (evaluated in the same cycle as the byte that entered it), in priority order:
  - Y[0] set: go to TA.
  - else Y[1]: go to TB.
  - else Y[2]: go to TC.
  - else Y[3]: go to TD.
  - else histLeft>0: go to HIST.
  - else needTck: go to TCK.
  - else: go to DONE.
  - Each consumed byte clears its Y bit.
- TA: when i==1, fiCode=hi nibble and diCode=lo nibble. Other TAi are consumed and ignored.
- TB, TC: consumed and ignored.
- TD: Y=hi nibble, then i=i+1.
  - T = lo nibble. T==0 sets useT0. T==1 sets useT1. T==15 sets useT15.
  - Any T!=0 sets needTck.
- HIST: decrement histLeft per byte.
- TCK: consume one byte, then DONE.
- Entering DONE: set atrCompleted=1. If tdSeen==0, set useT0=1 (implicit T=0).
- DONE and ERR hold until reset or isActivated low.
- T0 with K=0 and Y=0 completes on that byte.

Optional Feature:
- Macro: ISO7816_ATR_TCK_CHECK_EN.
- Defined:
  - Running XOR register starts at 0 and is XORed with every byte from T0 through TCK.
  - On the TCK byte, if XOR including TCK !=0, set tckError=1.
  - atrCompleted is still set.
- Undefined: no XOR register; tckError tied 0; TCK consumed unchecked.

Decomposition:
- Shared package iso7816_pkg holds:
  - state encoding: IDLE, WAIT_T0, NEXT, TA, TB, TC, TD, HIST, TCK, DONE, ERR;
  - protocol constants T_0=0, T_1=1, T_15=15;
  - default FI_CODE_DEFAULT/DI_CODE_DEFAULT=4'b0001;
  - MAX_ATR_BYTES default.
- One sub-module is natural: iso7816_atr_tck_checker (XOR accumulator plus compare), instantiated only under the macro.

Test Plan:
- tsReceived=1, byte 0x00 -> atrCompleted=1 next cycle, useT0=1, fiCode=1, diCode=1, atrByteCount=1.
- Bytes 0x11, 0x95, 0x80 -> after 3rd byte: fiCode=9, diCode=5, histCount=1, atrCompleted=1, useT0=1.
- Bytes 0x80, 0x01, 0x81 -> useT1=1, useT0=0, atrCompleted=1, tckError=0. Repeat with TCK=0x82 -> tckError=1 (macro on) or 0 (macro off).
- Byte 0x80, then 11 bytes of 0x80 (TD chain) and beyond, past 32 bytes -> atrError=1 on the 33rd byte, atrCompleted=0, further bytes ignored.
- Deactivate (isActivated=0) after 0x11 and before TA1 -> next cycle all outputs at reset values, state IDLE. Reactivate plus bytes 0x00 -> completes normally.
- byteValid coincident with reset -> byte ignored; outputs at reset values.
